dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-master arbiter and transaction sequencer in front of the shared `data_memory` block. Port 0 serves the CPU load/store unit; port 1 serves a secondary master (debug/loader/DMA). The block picks one pending request by round-robin, drives the memory command until `mem_ready`, returns read data with a one-cycle done pulse, and flags misaligned or timed-out accesses without hanging the requester.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `TIMEOUT`, 255, maximum cycles waiting for `mem_ready` before abort; must be 1..65535.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `m0_req`, `m1_req`  in  1  request valid; held until the matching `mN_done`.
- `m0_write`, `m1_write`  in  1  1 = store, 0 = load.
- `m0_addr`, `m1_addr`  in  ADDR_W  byte address.
- `m0_wdata`, `m1_wdata`  in  DATA_W  store data.
- `m0_funct3`, `m1_funct3`  in  3  RISC-V size/sign code (000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores 000/001/010).
- `m0_rdata`, `m1_rdata`  out  DATA_W  load result; valid while `mN_done`=1.
- `m0_done`, `m1_done`  out  1  one-cycle completion pulse.
- `m0_err`, `m1_err`  out  1  qualifies `mN_done`: misaligned or timeout.
- `mem_addr`  out  ADDR_W  to `data_memory.addr`.
- `mem_write_data`  out  DATA_W  to `data_memory.write_data`.
- `mem_write`, `mem_read`  out  1  memory command strobes.
- `mem_funct3`  out  3  to `data_memory.funct3`.
- `mem_read_data`  in  DATA_W  from memory.
- `mem_ready`  in  1  memory completion; may be high in the first command cycle.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE: if no request, stay. If exactly one `mN_req`, grant N. If both, grant the port not equal to `last_grant`. On grant, register addr/wdata/funct3/write of the winner, update `last_grant`, and run the alignment check:
  - misaligned = (funct3[1:0]=10 and addr[1:0]≠0) or (funct3[1:0]=01 and addr[0]≠0).
  - Misaligned: go to RESP with err=1; no memory strobe is ever issued.
  - Aligned: go to BUSY.
- BUSY: `mem_read` = !write, `mem_write` = write, address/data/funct3 from the registered copy, held stable. Timeout counter increments each BUSY cycle.
  - `mem_ready`=1: capture `mem_read_data` (loads only; stores capture 0), go to RESP with err=0.
  - Otherwise, if counter = TIMEOUT-1: go to RESP with err=1, rdata=0, strobes drop.
- RESP: assert granted `mN_done` (and `mN_err` if flagged) with `mN_rdata` for exactly one cycle; go to IDLE. The non-granted port's outputs stay 0.
- `mN_rdata` is 0 whenever `mN_done`=0.
- The requester deasserts or changes `mN_req` the cycle after `done`. A request still high in the cycle after RESP is treated as a new transaction.
- `mN_req` dropping during BUSY is ignored: the transaction completes and done still pulses.
- Reset values: state IDLE, `last_grant`=1 (port 0 wins the first tie), counter 0. All outputs 0.
- Reset during BUSY aborts immediately: strobes are 0 from the next edge and no done is issued.

## Timing
- Registered outputs only; no combinational path from `mN_req` to `mem_*`.
- Aligned access with zero-wait memory (`mem_ready`=1 in first BUSY cycle): req sampled at edge T, BUSY during T+1, done during T+2. Request-to-done is 2 cycles.
- Each additional memory wait cycle adds 1 cycle.
- Misaligned access: done+err during T+1.
- Timeout: exactly TIMEOUT BUSY cycles, then RESP.
- Back-to-back throughput: one transaction per 3 cycles minimum (IDLE→BUSY→RESP).
- Simultaneous new requests are resolved only in IDLE. With both ports continuously requesting, grants alternate 0,1,0,1…

## Test plan
- Single load: after reset, m0 lw addr 0x10 with memory word 0x12345678 and zero-wait memory → `mem_read`=1 for one cycle with `mem_addr`=0x10, `funct3`=010; `m0_done`=1, `m0_rdata`=0x12345678, `m0_err`=0 two cycles after request.
- Store then load: m1 sw 0xCAFEBABE to 0x20, then m1 lw 0x20 → `mem_write` pulse with data 0xCAFEBABE; the load returns 0xCAFEBABE; `m0_done` never asserts.
- Contention: m0 and m1 both hold requests for 4 transactions → grant order 0,1,0,1; each done pulses once; no strobe overlap.
- Misaligned: m0 lh addr 0x21; then lw addr 0x22 → each gives `m0_done`=`m0_err`=1 one cycle after request, with `mem_read`/`mem_write` never high.
- Timeout: TIMEOUT=8, `mem_ready` tied 0, m1 lw → `mem_read` high exactly 8 cycles, then `m1_done`=`m1_err`=1 with rdata 0, then IDLE accepts the next request.
- Reset mid-BUSY: `mem_ready` held 0, assert `rst` for one cycle during BUSY → strobes 0 next edge, no done pulse; after release, a tie grants port 0 first.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-master round-robin arbiter and transaction sequencer in front of data_memory.
// Grants one request in IDLE, drives the memory command in BUSY, and pulses done/err in RESP.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [2:0]        m0_funct3,
  input  logic              m1_req,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [2:0]        m1_funct3,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_done,
  output logic              m1_done,
  output logic              m0_err,
  output logic              m1_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write,
  output logic              mem_read,
  output logic [2:0]        mem_funct3,
  input  logic [DATA_W-1:0] mem_read_data,
  input  logic              mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                gnt_q, gnt_d;
  logic                write_q, write_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [2:0]          funct3_d;
  logic                read_strobe_d, write_strobe_d;
  logic [1:0]          done_d, err_d;
  logic [DATA_W-1:0]   rdata_d;

  // Winner selection: a lone requester wins, a tie goes to the port not served last.
  logic                pick;
  logic                pick_write;
  logic [ADDR_W-1:0]   pick_addr;
  logic [DATA_W-1:0]   pick_wdata;
  logic [2:0]          pick_funct3;
  logic                pick_misaligned;

  assign pick        = (m0_req && m1_req) ? ~last_grant_q : m1_req;
  assign pick_write  = pick ? m1_write  : m0_write;
  assign pick_addr   = pick ? m1_addr   : m0_addr;
  assign pick_wdata  = pick ? m1_wdata  : m0_wdata;
  assign pick_funct3 = pick ? m1_funct3 : m0_funct3;
  assign pick_misaligned = ((pick_funct3[1:0] == 2'b10) && (pick_addr[1:0] != 2'b00)) ||
                           ((pick_funct3[1:0] == 2'b01) && pick_addr[0]);

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    gnt_d          = gnt_q;
    write_d        = write_q;
    cnt_d          = cnt_q;
    addr_d         = mem_addr;
    wdata_d        = mem_write_data;
    funct3_d       = mem_funct3;
    read_strobe_d  = 1'b0;
    write_strobe_d = 1'b0;
    done_d         = 2'b00;
    err_d          = 2'b00;
    rdata_d        = '0;

    unique case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          gnt_d        = pick;
          last_grant_d = pick;
          write_d      = pick_write;
          addr_d       = pick_addr;
          wdata_d      = pick_wdata;
          funct3_d     = pick_funct3;
          cnt_d        = '0;
          if (pick_misaligned) begin
            state_d      = RESP;
            done_d[pick] = 1'b1;
            err_d[pick]  = 1'b1;
          end else begin
            state_d        = BUSY;
            read_strobe_d  = ~pick_write;
            write_strobe_d = pick_write;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (mem_ready) begin
          state_d       = RESP;
          done_d[gnt_q] = 1'b1;
          rdata_d       = write_q ? '0 : mem_read_data;
        end else if (cnt_q == TMO_LAST) begin
          state_d       = RESP;
          done_d[gnt_q] = 1'b1;
          err_d[gnt_q]  = 1'b1;
        end else begin
          read_strobe_d  = ~write_q;
          write_strobe_d = write_q;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      last_grant_q   <= 1'b1;
      gnt_q          <= 1'b0;
      write_q        <= 1'b0;
      cnt_q          <= '0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_funct3     <= '0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      m0_done        <= 1'b0;
      m1_done        <= 1'b0;
      m0_err         <= 1'b0;
      m1_err         <= 1'b0;
      m0_rdata       <= '0;
      m1_rdata       <= '0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      gnt_q          <= gnt_d;
      write_q        <= write_d;
      cnt_q          <= cnt_d;
      mem_addr       <= addr_d;
      mem_write_data <= wdata_d;
      mem_funct3     <= funct3_d;
      mem_read       <= read_strobe_d;
      mem_write      <= write_strobe_d;
      m0_done        <= done_d[0];
      m1_done        <= done_d[1];
      m0_err         <= err_d[0];
      m1_err         <= err_d[1];
      m0_rdata       <= done_d[0] ? rdata_d : '0;
      m1_rdata       <= done_d[1] ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic,
// with expected responses queued per port and compared by an independent monitor.
module tb_dmem_arbiter;

  localparam int TMO = 8;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]  m0_funct3, m1_funct3;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, m0_err, m1_err;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_write, mem_read, mem_ready;
  logic [2:0]  mem_funct3;

  exp_t        q0[$];
  exp_t        q1[$];
  int          grant_log[$];
  logic [31:0] mem_words [0:127];
  logic [31:0] ref_words [0:127];
  int          ready_mode;
  int          wait_cnt, wait_tgt;
  int          strobe_cycles, read_cycles;
  int          n_checks, n_pass;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_funct3(m0_funct3),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_funct3(m1_funct3),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata), .m0_done(m0_done), .m1_done(m1_done),
    .m0_err(m0_err), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_write(mem_write), .mem_read(mem_read),
    .mem_funct3(mem_funct3), .mem_read_data(mem_read_data), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h, required %h", name, act, exp);
  endtask

  // RISC-V byte/half/word semantics on a 32-bit memory word.
  function automatic logic [31:0] load_fmt(input logic [31:0] word, input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] s;
    s = word >> (8 * int'(off));
    case (f3)
      3'b000:  return {{24{s[7]}}, s[7:0]};
      3'b001:  return {{16{s[15]}}, s[15:0]};
      3'b100:  return {24'b0, s[7:0]};
      3'b101:  return {16'b0, s[15:0]};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] mask;
    case (f3[1:0])
      2'b00:   mask = 32'h0000_00FF;
      2'b01:   mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    mask = mask << (8 * int'(off));
    return (old & ~mask) | ((wd << (8 * int'(off))) & mask);
  endfunction

  // Reference model: outcome of a transaction computed from the access rules alone.
  task automatic model_issue(input int p, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                             input logic [2:0] f3, input bit tmo);
    exp_t e;
    bit   mis;
    e.err   = 1'b0;
    e.rdata = 32'h0;
    mis = ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00)) || ((f3[1:0] == 2'b01) && a[0]);
    if (mis || tmo) e.err = 1'b1;
    else if (wr) ref_words[a[8:2]] = store_merge(ref_words[a[8:2]], wd, f3, a[1:0]);
    else e.rdata = load_fmt(ref_words[a[8:2]], f3, a[1:0]);
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic start(input int p, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input bit track, input bit tmo);
    if (track) model_issue(p, wr, a, wd, f3, tmo);
    if (p == 0) begin
      m0_req = 1'b1; m0_write = wr; m0_addr = a; m0_wdata = wd; m0_funct3 = f3;
    end else begin
      m1_req = 1'b1; m1_write = wr; m1_addr = a; m1_wdata = wd; m1_funct3 = f3;
    end
  endtask

  task automatic stop(input int p);
    if (p == 0) m0_req = 1'b0;
    else m1_req = 1'b0;
  endtask

  task automatic wait_done(input int p, input int budget, output int cycles);
    logic d;
    cycles = 0;
    d = 1'b0;
    while (!d && cycles < budget) begin
      @(negedge clk);
      cycles++;
      d = (p == 0) ? m0_done : m1_done;
    end
    check($sformatf("m%0d_done_within_budget", p), {31'b0, d}, 32'd1);
  endtask

  task automatic run_port(input int p, input int n, input bit rnd);
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a, wd;
    int          cyc, k;
    for (int i = 0; i < n; i++) begin
      if (rnd) begin
        wr = ($urandom_range(0, 2) == 0);
        k  = wr ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 4));
        f3 = 3'(k < 3 ? k : k + 1);
        a  = 32'(p * 256 + int'($urandom_range(0, 255)));
        wd = $urandom;
      end else begin
        wr = 1'b0; f3 = 3'b010; wd = 32'h0;
        a  = 32'(p * 256 + 64 + 4 * i);
      end
      start(p, wr, a, wd, f3, 1'b1, 1'b0);
      wait_done(p, 64, cyc);
      @(posedge clk); #1;
      stop(p);
      k = rnd ? int'($urandom_range(0, 2)) : 0;
      if (k > 0) begin
        repeat (k) @(posedge clk);
        #1;
      end
    end
  endtask

  // Memory environment: ready after 0 (mode 0), 0..3 (mode 1) or never (mode 2) wait cycles.
  always @(negedge clk) begin
    if (!(mem_read || mem_write)) begin
      mem_ready = 1'b0;
      wait_cnt  = 0;
      wait_tgt  = (ready_mode == 1) ? int'($urandom_range(0, 3)) : 0;
    end else if (ready_mode != 2 && wait_cnt >= wait_tgt) begin
      mem_ready = 1'b1;
      if (mem_write) begin
        mem_words[mem_addr[8:2]] = store_merge(mem_words[mem_addr[8:2]], mem_write_data, mem_funct3, mem_addr[1:0]);
        mem_read_data = $urandom;
      end else begin
        mem_read_data = load_fmt(mem_words[mem_addr[8:2]], mem_funct3, mem_addr[1:0]);
      end
    end else begin
      mem_ready     = 1'b0;
      mem_read_data = $urandom;
      wait_cnt++;
    end
  end

  task automatic mon_port(input int p, input logic done, input logic err, input logic [31:0] rdata);
    exp_t e;
    if (done) begin
      grant_log.push_back(p);
      if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
        check($sformatf("m%0d_unexpected_done", p), {31'b0, done}, 32'd0);
      end else begin
        e = (p == 0) ? q0.pop_front() : q1.pop_front();
        check($sformatf("m%0d_err", p), {31'b0, err}, {31'b0, e.err});
        check($sformatf("m%0d_rdata", p), rdata, e.rdata);
      end
    end else begin
      check($sformatf("m%0d_idle_outputs", p), rdata | {31'b0, err}, 32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (mem_read || mem_write) begin
      strobe_cycles++;
      check("strobe_overlap", {31'b0, mem_read & mem_write}, 32'd0);
    end
    if (mem_read) read_cycles++;
    if (m0_done || m1_done) check("done_overlap", {31'b0, m0_done & m1_done}, 32'd0);
    mon_port(0, m0_done, m0_err, m0_rdata);
    mon_port(1, m1_done, m1_err, m1_rdata);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed by main sequence");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cyc, s0, r0;
    rst = 1'b1;
    m0_req = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0; m0_funct3 = 0;
    m1_req = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0; m1_funct3 = 0;
    mem_ready = 0; mem_read_data = 0; ready_mode = 0;
    strobe_cycles = 0; read_cycles = 0; n_checks = 0; n_pass = 0;
    for (int i = 0; i < 128; i++) begin
      mem_words[i] = $urandom;
      ref_words[i] = mem_words[i];
    end

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_read", {31'b0, mem_read}, 32'd0);
    check("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_done", {30'b0, m1_done, m0_done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single zero-wait load.
    mem_words[4] = 32'h1234_5678;
    ref_words[4] = 32'h1234_5678;
    start(0, 1'b0, 32'h10, 32'h0, 3'b010, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("load_mem_read", {31'b0, mem_read}, 32'd1);
    check("load_mem_addr", mem_addr, 32'h10);
    check("load_mem_funct3", {29'b0, mem_funct3}, 32'd2);
    wait_done(0, 20, cyc);
    check("load_done_cycle", cyc, 32'd1);
    @(posedge clk); #1;
    stop(0);

    // Store then load from port 1.
    start(1, 1'b1, 32'h20, 32'hCAFE_BABE, 3'b010, 1'b1, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("store_mem_write", {31'b0, mem_write}, 32'd1);
    check("store_mem_wdata", mem_write_data, 32'hCAFE_BABE);
    check("store_mem_addr", mem_addr, 32'h20);
    wait_done(1, 20, cyc);
    check("store_done_cycle", cyc, 32'd1);
    @(posedge clk); #1;
    start(1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b1, 1'b0);
    @(posedge clk);
    wait_done(1, 20, cyc);
    check("reload_done_cycle", cyc, 32'd2);
    @(posedge clk); #1;
    stop(1);

    // Contention: both ports hold requests for two transactions each.
    ready_mode = 1;
    grant_log.delete();
    fork
      run_port(0, 2, 1'b0);
      run_port(1, 2, 1'b0);
    join
    check("contention_grant_count", grant_log.size(), 32'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check($sformatf("contention_grant_%0d", i), grant_log[i], i % 2);

    // Misaligned half and word loads.
    ready_mode = 0;
    s0 = strobe_cycles;
    start(0, 1'b0, 32'h21, 32'h0, 3'b001, 1'b1, 1'b0);
    @(posedge clk);
    wait_done(0, 20, cyc);
    check("mis_lh_done_cycle", cyc, 32'd1);
    check("mis_lh_err", {31'b0, m0_err}, 32'd1);
    @(posedge clk); #1;
    start(0, 1'b0, 32'h22, 32'h0, 3'b010, 1'b1, 1'b0);
    @(posedge clk);
    wait_done(0, 20, cyc);
    check("mis_lw_done_cycle", cyc, 32'd1);
    check("mis_lw_err", {31'b0, m0_err}, 32'd1);
    @(posedge clk); #1;
    stop(0);
    check("mis_no_strobes", strobe_cycles - s0, 32'd0);

    // Timeout with memory never ready, then a normal access.
    ready_mode = 2;
    r0 = read_cycles;
    start(1, 1'b0, 32'h30, 32'h0, 3'b010, 1'b1, 1'b1);
    @(posedge clk);
    wait_done(1, 40, cyc);
    check("timeout_done_cycle", cyc, TMO + 1);
    check("timeout_read_cycles", read_cycles - r0, TMO);
    @(posedge clk); #1;
    ready_mode = 0;
    start(1, 1'b0, 32'h34, 32'h0, 3'b010, 1'b1, 1'b0);
    @(posedge clk);
    wait_done(1, 20, cyc);
    check("after_timeout_done_cycle", cyc, 32'd2);
    @(posedge clk); #1;
    stop(1);

    // Reset during BUSY, then a tie must go to port 0.
    ready_mode = 2;
    start(0, 1'b0, 32'h50, 32'h0, 3'b010, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("pre_reset_busy", {31'b0, mem_read}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    stop(0);
    @(posedge clk);
    @(negedge clk);
    check("reset_drops_strobes", {30'b0, mem_read, mem_write}, 32'd0);
    check("reset_no_done", {30'b0, m1_done, m0_done}, 32'd0);
    rst = 1'b0;
    s0 = strobe_cycles;
    repeat (6) @(negedge clk);
    check("reset_idle_strobes", strobe_cycles - s0, 32'd0);
    @(posedge clk); #1;
    ready_mode = 0;
    grant_log.delete();
    fork
      run_port(0, 1, 1'b0);
      run_port(1, 1, 1'b0);
    join
    check("post_reset_grant_count", grant_log.size(), 32'd2);
    if (grant_log.size() > 0) check("post_reset_first_grant", grant_log[0], 32'd0);

    // Randomized concurrent traffic on disjoint address regions.
    ready_mode = 1;
    fork
      run_port(0, 60, 1'b1);
      run_port(1, 60, 1'b1);
    join
    repeat (4) @(posedge clk);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
